mult_arbiter: RTL

//  Round-robin arbiter and pipeline around one shared signed Q1.15 multiply-shift unit.

---
 rtl/mult_arbiter_if.sv | 24 ++
 rtl/mult_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: request/grant and result bus between effect stages and mult_arbiter
//   master : requester side  (drives i_req, i_a, i_b; sees o_gnt, o_valid, o_id, o_data)
//   slave  : arbiter side    (sees i_req, i_a, i_b; drives o_gnt, o_valid, o_id, o_data)
//   i_req   NUM_REQ          request bit per requester
//   i_a/i_b NUM_REQ*DATA_W   signed operands, slice k = [k*DATA_W +: DATA_W]
//   o_gnt   NUM_REQ          one-hot grant pulse
//   o_valid 1                o_data/o_id valid
//   o_id    $clog2(NUM_REQ)  owner of o_data
//   o_data  DATA_W           signed (A*B) >>> FRAC
interface mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
) ();
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*DATA_W-1:0] i_a;
    logic [NUM_REQ*DATA_W-1:0] i_b;
    logic [NUM_REQ-1:0]        o_gnt;
    logic                      o_valid;
    logic [ID_W-1:0]           o_id;
    logic [DATA_W-1:0]         o_data;
    modport master (output i_req, i_a, i_b, input o_gnt, o_valid, o_id, o_data);
    modport slave  (input i_req, i_a, i_b, output o_gnt, o_valid, o_id, o_data);
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter feeding one shared signed Q1.15 multiply-shift pipeline
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      mult_arbiter_if.slave (requests, operands, grants, tagged results)
//   Latency: o_valid rises two cycles after the matching o_gnt pulse.
//   Option: define MULT_ARB_SAT_EN to clamp results to the DATA_W signed range;
//           otherwise the shifted product is truncated to DATA_W bits.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int FRAC    = 15
) (
    input logic           i_clk,
    input logic           i_rst_n,
    mult_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         eligible, gnt_q, gnt_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d, win;
    logic [ID_W:0]              idx;
    logic                       found;
    logic signed [DATA_W-1:0]   a_sel, b_sel, s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]            s1_id_q, s1_id_d, s2_id_q, s2_id_d, id_q, id_d;
    logic                       s1_v_q, s1_v_d, s2_v_q, s2_v_d, valid_q, valid_d;
    logic signed [2*DATA_W-1:0] s2_p_q, s2_p_d;
    logic [DATA_W-1:0]          data_sel, data_q, data_d;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    // A requester granted on the previous edge is masked out for this one.
    always_comb begin
        eligible = bus.i_req & ~gnt_q;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (eligible[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                a_sel = bus.i_a[i*DATA_W +: DATA_W];
                b_sel = bus.i_b[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MULT_ARB_SAT_EN
    localparam logic signed [2*DATA_W-1:0] MAX_V = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] MIN_V = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [2*DATA_W-1:0] shifted;
    always_comb begin
        shifted  = s2_p_q >>> FRAC;
        data_sel = shifted > MAX_V ? MAX_V[DATA_W-1:0] :
                   shifted < MIN_V ? MIN_V[DATA_W-1:0] : shifted[DATA_W-1:0];
    end
`else
    always_comb data_sel = DATA_W'(s2_p_q >>> FRAC);
`endif

    always_comb begin
        gnt_d    = found ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
        rr_ptr_d = !found ? rr_ptr_q : (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        s1_v_d   = found;
        s1_id_d  = found ? win : s1_id_q;
        s1_a_d   = found ? a_sel : s1_a_q;
        s1_b_d   = found ? b_sel : s1_b_q;
        s2_v_d   = s1_v_q;
        s2_id_d  = s1_id_q;
        s2_p_d   = s1_a_q * s1_b_q;
        valid_d  = s2_v_q;
        id_d     = s2_v_q ? s2_id_q : id_q;
        data_d   = s2_v_q ? data_sel : data_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            s1_v_q   <= 1'b0;
            s1_id_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_v_q   <= 1'b0;
            s2_id_q  <= '0;
            s2_p_q   <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            data_q   <= '0;
        end else begin
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            s1_v_q   <= s1_v_d;
            s1_id_q  <= s1_id_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_v_q   <= s2_v_d;
            s2_id_q  <= s2_id_d;
            s2_p_q   <= s2_p_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            data_q   <= data_d;
        end
    end

    assign bus.o_gnt   = gnt_q;
    assign bus.o_valid = valid_q;
    assign bus.o_id    = id_q;
    assign bus.o_data  = data_q;
endmodule
